// File: rtl/execute_pipe.sv
// execute_pipe: Y86-64 execute stage that owns the {OF,SF,ZF} CC register and feeds a single-entry E/M output buffer.
// Latency: 1 cycle for every op. With EXEC_MUL_EN, mulq lands in the buffer WIDTH cycles after the accept edge.
// Backpressure: in_ready is low while the buffer is full and not being drained this cycle, or while a multiply is in flight.
// Optional feature: define EXEC_MUL_EN to make icode 6 / ifun 4 an iterative shift-add mulq. Without it, ifun 4 is illegal.
module execute_pipe #(
    parameter int WIDTH      = 64,
    parameter int STACK_STEP = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [WIDTH-1:0] valC,
    input  logic             set_cc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_valE,
    output logic             out_cnd,
    output logic [3:0]       out_icode,
    output logic             out_err,
    output logic [2:0]       cc
);
    localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);
    localparam int               MSB  = WIDTH - 1;

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    state_t           state_q;
    state_t           state_d;

    logic             buf_free;
    logic             accept;
    logic             mul_load;
    logic             mul_done;
    logic             mul_setcc;
    logic [WIDTH-1:0] mul_result;

    logic [WIDTH-1:0] alu_valE;
    logic             alu_cnd;
    logic             alu_err;
    logic             alu_is_op;
    logic             alu_of;
    logic             alu_mul;
    logic [2:0]       alu_cc;

    logic             flag_of;
    logic             flag_sf;
    logic             flag_zf;
    logic             flag_lt;

    assign {flag_of, flag_sf, flag_zf} = cc;
    assign flag_lt  = flag_sf ^ flag_of;
    assign buf_free = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Single-cycle datapath: valE, condition outcome, legality and OF for the presented instruction.
    always_comb begin
        alu_valE  = '0;
        alu_cnd   = 1'b0;
        alu_err   = 1'b0;
        alu_is_op = 1'b0;
        alu_of    = 1'b0;
        alu_mul   = 1'b0;
        case (icode)
            4'h2, 4'h7: begin
                if (icode == 4'h2) begin
                    alu_valE = valA;
                end
                case (ifun)
                    4'h0:    alu_cnd = 1'b1;
                    4'h1:    alu_cnd = flag_lt | flag_zf;
                    4'h2:    alu_cnd = flag_lt;
                    4'h3:    alu_cnd = flag_zf;
                    4'h4:    alu_cnd = !flag_zf;
                    4'h5:    alu_cnd = !flag_lt;
                    4'h6:    alu_cnd = !flag_lt && !flag_zf;
                    default: alu_err = 1'b1;
                endcase
            end
            4'h3, 4'h4, 4'h5: alu_valE = valC + valB;
            4'h6: begin
                case (ifun)
                    4'h0: begin
                        alu_is_op = 1'b1;
                        alu_valE  = valB + valA;
                        alu_of    = (valB[MSB] == valA[MSB]) && (alu_valE[MSB] != valB[MSB]);
                    end
                    4'h1: begin
                        alu_is_op = 1'b1;
                        alu_valE  = valB - valA;
                        alu_of    = (valB[MSB] != valA[MSB]) && (alu_valE[MSB] != valB[MSB]);
                    end
                    4'h2: begin
                        alu_is_op = 1'b1;
                        alu_valE  = valB & valA;
                    end
                    4'h3: begin
                        alu_is_op = 1'b1;
                        alu_valE  = valB ^ valA;
                    end
`ifdef EXEC_MUL_EN
                    4'h4:    alu_mul = 1'b1;
`endif
                    default: alu_err = 1'b1;
                endcase
            end
            4'h8, 4'hA: alu_valE = valB - STEP;
            4'h9, 4'hB: alu_valE = valB + STEP;
            4'h0, 4'h1: alu_valE = '0;
            default:    alu_err  = 1'b1;
        endcase
    end

    assign alu_cc = {alu_of, alu_valE[MSB], alu_valE == '0};

`ifdef EXEC_MUL_EN
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(WIDTH);

    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] mul_mcand;
    logic [WIDTH-1:0] mul_mplier;
    logic [WIDTH-1:0] mul_acc_next;
    logic [CNT_W-1:0] mul_cnt;
    logic             mul_step;

    // One multiplier bit per MUL cycle; once the counter hits WIDTH the product is frozen until the buffer frees.
    assign mul_step     = (state_q == S_MUL) && (mul_cnt != CNT_END);
    assign mul_acc_next = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;
    assign mul_result   = mul_step ? mul_acc_next : mul_acc;
    assign mul_done     = (mul_cnt == CNT_LAST) || (mul_cnt == CNT_END);

    // Multiplier operand/accumulator registers: loaded on accept, shifted each MUL step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_cnt    <= '0;
            mul_setcc  <= 1'b0;
        end else if (accept && alu_mul) begin
            mul_acc    <= '0;
            mul_mcand  <= valB;
            mul_mplier <= valA;
            mul_cnt    <= '0;
            mul_setcc  <= set_cc_en;
        end else if (mul_step) begin
            mul_acc    <= mul_acc_next;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt + CNT_W'(1);
        end
    end
`else
    assign mul_result = '0;
    assign mul_done   = 1'b0;
    assign mul_setcc  = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a mulq accept enters MUL, delivering its product returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && alu_mul) state_d = S_MUL;
            S_MUL:   if (mul_load) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: accept only when idle with room in the buffer; deliver the product when done and the buffer is free.
    always_comb begin
        in_ready = 1'b0;
        mul_load = 1'b0;
        case (state_q)
            S_IDLE:  in_ready = buf_free;
            S_MUL:   mul_load = mul_done && buf_free;
            default: ;
        endcase
    end

    // E/M output buffer: a single-cycle result or the finished product loads it, otherwise out_ready drains it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_valE  <= '0;
            out_cnd   <= 1'b0;
            out_icode <= 4'h0;
            out_err   <= 1'b0;
        end else if (accept && !alu_mul) begin
            out_valid <= 1'b1;
            out_valE  <= alu_valE;
            out_cnd   <= alu_cnd;
            out_icode <= icode;
            out_err   <= alu_err;
        end else if (mul_load) begin
            out_valid <= 1'b1;
            out_valE  <= mul_result;
            out_cnd   <= 1'b0;
            out_icode <= 4'h6;
            out_err   <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // CC register: written on the same edge as the result that produced the flags; mulq never overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc <= 3'b001;
        end else if (accept && alu_is_op && set_cc_en) begin
            cc <= alu_cc;
        end else if (mul_load && mul_setcc) begin
            cc <= {1'b0, mul_result[MSB], mul_result == '0};
        end
    end

endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe: directed stimulus for execute_pipe with a cycle-level reference model and literal spot checks.
// Latency: checks outputs every cycle, 3 time units after the falling edge.
// Backpressure: exercises out_ready hold/release and mulq stalls when EXEC_MUL_EN is defined.
module tb_execute_pipe;
    localparam int W = 64;
`ifdef EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [W-1:0] valA;
    logic [W-1:0] valB;
    logic [W-1:0] valC;
    logic         set_cc_en;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_valE;
    logic         out_cnd;
    logic [3:0]   out_icode;
    logic         out_err;
    logic [2:0]   cc;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    execute_pipe #(.WIDTH(W), .STACK_STEP(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
        .set_cc_en(set_cc_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_valE(out_valE), .out_cnd(out_cnd), .out_icode(out_icode),
        .out_err(out_err), .cc(cc)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference semantics of one instruction, from the instruction-set rules.
    function automatic void mexec(input logic [3:0] ic, input logic [3:0] fn,
                                  input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                                  input logic [2:0] ccin, output logic [W-1:0] ve, output logic cn,
                                  output logic er, output logic wr, output logic [2:0] ccn);
        logic [W:0] wide;
        logic       ovf;
        logic       lt;
        ve   = '0;
        cn   = 1'b0;
        er   = 1'b0;
        wr   = 1'b0;
        ovf  = 1'b0;
        wide = '0;
        lt   = ccin[1] ^ ccin[2];
        case (ic)
            4'h2, 4'h7: begin
                if (ic == 4'h2) ve = a;
                case (fn)
                    4'h0:    cn = 1'b1;
                    4'h1:    cn = lt | ccin[0];
                    4'h2:    cn = lt;
                    4'h3:    cn = ccin[0];
                    4'h4:    cn = !ccin[0];
                    4'h5:    cn = !lt;
                    4'h6:    cn = !lt && !ccin[0];
                    default: er = 1'b1;
                endcase
            end
            4'h3, 4'h4, 4'h5: ve = c + b;
            4'h6: begin
                wr = 1'b1;
                case (fn)
                    4'h0: begin wide = {b[W-1], b} + {a[W-1], a}; ve = wide[W-1:0]; ovf = wide[W] ^ wide[W-1]; end
                    4'h1: begin wide = {b[W-1], b} - {a[W-1], a}; ve = wide[W-1:0]; ovf = wide[W] ^ wide[W-1]; end
                    4'h2: ve = b & a;
                    4'h3: ve = b ^ a;
                    default: begin wr = 1'b0; er = 1'b1; end
                endcase
            end
            4'h8, 4'hA: ve = b - W'(8);
            4'h9, 4'hB: ve = b + W'(8);
            4'h0, 4'h1: ve = '0;
            default:    er = 1'b1;
        endcase
        ccn = wr ? {ovf, ve[W-1], ve == '0} : ccin;
    endfunction

    // Model state: buffer contents, CC, and a countdown for an in-flight multiply.
    logic         m_valid, m_cnd, m_err, m_busy, m_psetcc;
    logic [W-1:0] m_valE, m_prod;
    logic [3:0]   m_icode;
    logic [2:0]   m_cc;
    int           m_cnt;
    logic         m_rdy;
    logic [W-1:0] e_ve;
    logic         e_cn, e_er, e_wr;
    logic [2:0]   e_cc;

    assign m_rdy = !m_busy && (!m_valid || out_ready);

    always_comb begin
        mexec(icode, ifun, valA, valB, valC, m_cc, e_ve, e_cn, e_er, e_wr, e_cc);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0; m_valE <= '0; m_cnd <= 1'b0; m_icode <= 4'h0; m_err <= 1'b0;
            m_cc <= 3'b001; m_busy <= 1'b0; m_cnt <= 0; m_prod <= '0; m_psetcc <= 1'b0;
        end else if (in_valid && m_rdy && MUL_EN && icode == 4'h6 && ifun == 4'h4) begin
            m_busy   <= 1'b1;
            m_cnt    <= W;
            m_prod   <= valB * valA;
            m_psetcc <= set_cc_en;
            if (out_ready) m_valid <= 1'b0;
        end else if (in_valid && m_rdy) begin
            m_valid <= 1'b1; m_valE <= e_ve; m_cnd <= e_cn; m_icode <= icode; m_err <= e_er;
            if (e_wr && set_cc_en) m_cc <= e_cc;
        end else if (m_busy && m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
            if (out_ready) m_valid <= 1'b0;
        end else if (m_busy && (!m_valid || out_ready)) begin
            m_valid <= 1'b1; m_valE <= m_prod; m_cnd <= 1'b0; m_icode <= 4'h6; m_err <= 1'b0;
            m_busy  <= 1'b0;
            if (m_psetcc) m_cc <= {1'b0, m_prod[W-1], m_prod == '0};
        end else if (!m_busy && out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        #3;
        if (started) begin
            chk("in_ready", in_ready, m_rdy);
            chk("out_valid", out_valid, m_valid);
            chk("cc", cc, m_cc);
            if (m_valid) begin
                chk("out_valE", out_valE, m_valE);
                chk("out_cnd", out_cnd, m_cnd);
                chk("out_icode", out_icode, m_icode);
                chk("out_err", out_err, m_err);
            end
        end
    end

    task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c, input logic sc);
        int k;
        @(negedge clk);
        #1;
        in_valid = 1'b1; icode = ic; ifun = fn; valA = a; valB = b; valC = c; set_cc_en = sc;
        #1;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("accept_timeout", in_ready, 1);
        @(posedge clk);
    endtask

    task automatic drop();
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        #3;
    endtask

    typedef struct packed {
        logic [3:0]   ic;
        logic [3:0]   fn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
    } vec_t;

    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

    vec_t tbl [18] = '{
        '{4'h6, 4'h0, MIN, MIN, 64'h0},
        '{4'h2, 4'h1, 64'hAA, 64'h0, 64'h0},
        '{4'h6, 4'h1, 64'h1, MIN, 64'h0},
        '{4'h7, 4'h2, 64'h0, 64'h0, 64'h0},
        '{4'h6, 4'h2, 64'hF0, 64'h3C, 64'h0},
        '{4'h6, 4'h3, 64'h55, 64'h55, 64'h0},
        '{4'h7, 4'h3, 64'h0, 64'h0, 64'h0},
        '{4'h7, 4'h4, 64'h0, 64'h0, 64'h0},
        '{4'h7, 4'h5, 64'h0, 64'h0, 64'h0},
        '{4'h7, 4'h0, 64'h0, 64'h0, 64'h0},
        '{4'h7, 4'h7, 64'h0, 64'h0, 64'h0},
        '{4'h6, 4'h5, 64'h1, 64'h1, 64'h0},
        '{4'h4, 4'h0, 64'h0, 64'h20, 64'h10},
        '{4'h5, 4'h0, 64'h0, {W{1'b1}}, 64'h2},
        '{4'h8, 4'h0, 64'h0, 64'h108, 64'h0},
        '{4'h9, 4'h0, 64'h0, 64'h100, 64'h0},
        '{4'hC, 4'h0, 64'h0, 64'h0, 64'h0},
        '{4'h2, 4'h6, 64'h77, 64'h0, 64'h0}
    };

    initial begin
        int lowcnt;
        in_valid = 1'b0; icode = 4'h0; ifun = 4'h0; valA = '0; valB = '0; valC = '0;
        set_cc_en = 1'b1; out_ready = 1'b1; rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_valE", out_valE, 0);
        chk("rst_out_cnd", out_cnd, 0);
        chk("rst_out_icode", out_icode, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_cc", cc, 3'b001);
        chk("rst_in_ready", in_ready, 1);
        #19 rst_n = 1'b1;
        started = 1'b1;

        // addq overflow into the sign bit
        issue(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        drop();
        chk("addq_valE", out_valE, 64'h8000_0000_0000_0000);
        chk("addq_cc", cc, 3'b110);

        // subq to zero, then conditional jumps on the new flags
        issue(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 1'b1);
        drop();
        chk("subq_valE", out_valE, 0);
        chk("subq_cc", cc, 3'b001);
        issue(4'h7, 4'h1, 64'd0, 64'd0, 64'd0, 1'b1);
        drop();
        chk("jle_cnd", out_cnd, 1);
        issue(4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 1'b1);
        drop();
        chk("jg_cnd", out_cnd, 0);

        // stack pointer adjust, CC untouched
        issue(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 1'b1);
        drop();
        chk("pushq_valE", out_valE, 64'hF8);
        issue(4'hB, 4'h0, 64'd0, 64'hF8, 64'd0, 1'b1);
        drop();
        chk("popq_valE", out_valE, 64'h100);
        chk("popq_cc", cc, 3'b001);

        // CC write suppressed
        issue(4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 1'b0);
        drop();
        chk("nocc_valE", out_valE, 64'd3);
        chk("nocc_cc", cc, 3'b001);

        // downstream stall: result held, new instruction waits, then refill on release
        @(negedge clk);
        #1 out_ready = 1'b0;
        issue(4'h3, 4'h0, 64'd0, 64'd0, 64'h11, 1'b1);
        @(negedge clk);
        #1 valC = 64'h22;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #4;
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_valE", out_valE, 64'h11);
        out_ready = 1'b1;
        @(posedge clk);
        drop();
        chk("release_out_valE", out_valE, 64'h22);
        chk("release_out_valid", out_valid, 1);

        // mulq
        issue(4'h6, 4'h4, 64'd7, 64'd6, 64'd0, 1'b1);
`ifdef EXEC_MUL_EN
        lowcnt = 0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            #1 in_valid = 1'b0;
            #3;
            if (!in_ready && !out_valid) lowcnt++;
        end
        chk("mul_busy_cycles", lowcnt, W);
        @(negedge clk);
        #4;
        chk("mul_out_valid", out_valid, 1);
        chk("mul_valE", out_valE, 64'd42);
        chk("mul_cc", cc, 3'b000);
`else
        lowcnt = 0;
        drop();
        chk("mul_illegal_err", out_err, 1);
        chk("mul_illegal_valE", out_valE, 0);
        chk("mul_illegal_cc", cc, 3'b001);
`endif

        // back-to-back table, model-checked each cycle
        foreach (tbl[i]) begin
            issue(tbl[i].ic, tbl[i].fn, tbl[i].a, tbl[i].b, tbl[i].c, 1'b1);
        end
        drop();

        // reset in the middle of a multiply (a plain addq without the multiplier)
        issue(4'h6, MUL_EN ? 4'h4 : 4'h0, 64'd3, 64'd5, 64'd0, 1'b1);
        drop();
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #3;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_cc", cc, 3'b001);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        lowcnt = 0;
        repeat (W + 8) begin
            @(negedge clk);
            #4;
            if (out_valid) lowcnt++;
        end
        chk("midrst_no_late_result", lowcnt, 0);
        chk("midrst_idle_ready", in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/execute_pipe.md
Name: execute_pipe

Overview:
- Parametrised, pipelined successor to the combinational Y86-64 execute stage.
- Computes valE and cnd, and owns the architectural condition-code register (OF, SF, ZF).
- Registers its result into a single-entry E/M output buffer with a valid/ready handshake on both sides.
- Sits between decode and memory in the pipelined core. An optional iterative multiplier adds multi-cycle behaviour.

Parameters:
- WIDTH, 64, datapath width of valA/valB/valC/valE (minimum 8).
- STACK_STEP, 8, amount added to or subtracted from valB for call/ret/pushq/popq.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- icode  in  4  instruction code.
- ifun  in  4  function code.
- valA  in  WIDTH  operand A.
- valB  in  WIDTH  operand B.
- valC  in  WIDTH  constant.
- set_cc_en  in  1  enables CC update for the instruction being accepted (low when a later stage has an exception).
- out_valid  out  1  output buffer holds a result.
- out_ready  in  1  memory stage consumes the result.
- out_valE  out  WIDTH  result.
- out_cnd  out  1  condition outcome.
- out_icode  out  4  icode of the buffered result.
- out_err  out  1  illegal icode/ifun flag.
- cc  out  3  {OF,SF,ZF}, the current CC register.

Behaviour:
- Reset (asynchronous, active-low): out_valid=0, out_valE=0, out_cnd=0, out_icode=0, out_err=0, cc=3'b001, FSM=IDLE. Assertion mid-multiply aborts the multiply with no output and no CC change.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready.
- Single-cycle ops: result is loaded into the output buffer on the accept edge, so latency is 1. out_valid stays 1 until out_ready is seen, or until it is refilled by a simultaneous accept.
- valE per icode:
  - 2 (cmovXX): valA.
  - 3, 4, 5: valC+valB.
  - 6 (OPq):
    - ifun 0: valB+valA.
    - ifun 1: valB-valA.
    - ifun 2: valB&valA.
    - ifun 3: valB^valA.
  - 8, A: valB-STACK_STEP.
  - 9, B: valB+STACK_STEP.
  - 0, 1, 7: 0.
  - Any other icode: valE=0, out_err=1.
  - All arithmetic is modulo 2^WIDTH.
- cnd, for icode 2 and 7, is evaluated from the CC register value before this instruction's update:
  - ifun 0: 1.
  - ifun 1 (le): (SF^OF)|ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): !ZF.
  - ifun 5 (ge): !(SF^OF).
  - ifun 6 (g): !(SF^OF)&!ZF.
  - ifun>6: cnd=0, out_err=1.
  - All other icodes: cnd=0.
- CC update, only for icode 6 with set_cc_en=1 and a legal ifun:
  - ZF = (valE==0).
  - SF = valE[WIDTH-1].
  - OF for add: operands share a sign and the result sign differs.
  - OF for sub: sign(valB)!=sign(valA) and sign(result)!=sign(valB).
  - OF for logic ops and mul: 0.
- The CC register updates on the same edge that loads the result. The next accepted instruction sees the new flags.
- Illegal OPq ifun (>3, or ifun 4 without the multiplier): valE=0, out_err=1, CC unchanged.
- Back-to-back accepts with out_ready held high give one result per cycle.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro EXEC_MUL_EN.
- Defined: icode 6 ifun 4 is mulq. It returns the low WIDTH bits of valB*valA via a shift-add FSM (IDLE -> MUL -> IDLE).
  - Accept edge: latch the operands, counter=0, enter MUL, in_ready=0.
  - Each MUL cycle processes one multiplier bit. After WIDTH cycles in MUL, the result is loaded into the output buffer and the CC is updated, using the set_cc_en value captured at accept. The FSM then returns to IDLE.
  - The result edge is WIDTH cycles after the accept edge.
  - If the output buffer is still occupied when the counter reaches WIDTH, the FSM holds in MUL until the buffer is free.
- Undefined: ifun 4 is illegal, and the FSM never leaves IDLE.

Test Plan:
- Reset then addq with valA=1, valB=0x7FFF_FFFF_FFFF_FFFF (WIDTH=64) -> out_valE=0x8000_0000_0000_0000, cc=3'b110 one cycle after accept.
- subq with valA=5, valB=5 -> valE=0, cc=001. Next jle (icode 7, ifun 1) -> out_cnd=1. Next jg -> out_cnd=0.
- pushq with valB=0x100 -> 0xF8; popq with valB=0xF8 -> 0x100; cc unchanged.
- addq with set_cc_en=0 after an earlier cc=001 -> cc stays 001.
- Hold out_ready=0 after one result -> in_ready=0 and out_valE stable. Release out_ready -> next accept completes with no result lost or duplicated.
- EXEC_MUL_EN: mulq with valA=7, valB=6 -> in_ready low for 64 cycles, then out_valE=42, cc=000. Assert rst_n low mid-multiply -> out_valid=0, cc=001, FSM IDLE.
